// File: rtl/guitar_pkg.sv
// Shared types and default parameters for the guitar input front end.
package guitar_pkg;
  localparam int NUM_LANES = 4;

  typedef logic [NUM_LANES-1:0] lane_row_t;

  localparam int DEF_CLK_DIV         = 50000;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_LANE_DEPTH      = 16;
  localparam int DEF_HIT_POS         = 1;
endpackage

// File: rtl/guitar_debounce.sv
// Two-flop synchroniser followed by an independent per-bit stability counter.
module guitar_debounce #(
  parameter int WIDTH  = 5,
  parameter int CYCLES = 1000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);
  // Counter only ever reaches CYCLES-1 before it clears.
  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(CYCLES - 1)) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/guitar_input_frontend.sv
// Debounced frets/strum, gameclk beat divider and scrolling 4-lane note chart feeding the processor.
module guitar_input_frontend
  import guitar_pkg::*;
#(
  parameter int CLK_DIV         = DEF_CLK_DIV,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LANE_DEPTH      = DEF_LANE_DEPTH,
  parameter int HIT_POS         = DEF_HIT_POS
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_LANES-1:0]            btn_raw,
  input  logic                            strum_raw,
  input  logic                            run,
  input  logic [NUM_LANES-1:0]            chart_notes,
  input  logic                            chart_valid,
  output logic                            chart_ready,
  output logic [NUM_LANES-1:0]            buttons,
  output logic                            strum,
  output logic                            gameclk,
  output logic [NUM_LANES-1:0]            intersections,
  output logic [NUM_LANES*LANE_DEPTH-1:0] lanes_flat,
  output logic                            underrun
);
  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             gameclk_q, gameclk_d;
  logic             underrun_q, underrun_d;
  lane_row_t        slot_q [LANE_DEPTH];
  lane_row_t        slot_d [LANE_DEPTH];
  logic [NUM_LANES:0] db_stable;
  logic             wrap;
  logic             tick;

  guitar_debounce #(
    .WIDTH  (NUM_LANES + 1),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i    (clock),
    .rst_ni   (reset),
    .raw_i    ({strum_raw, btn_raw}),
    .stable_o (db_stable)
  );

  assign wrap = (div_q == DIV_W'(CLK_DIV - 1));
  // Tick marks the rising edge of gameclk; dropping run suppresses it in the same cycle.
  assign tick = run && wrap && !gameclk_q;

  always_comb begin
    div_d      = div_q;
    gameclk_d  = gameclk_q;
    underrun_d = underrun_q;
    for (int i = 0; i < LANE_DEPTH; i++) slot_d[i] = slot_q[i];
    if (run) begin
      if (wrap) begin
        div_d     = '0;
        gameclk_d = ~gameclk_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
    if (tick) begin
      for (int i = 0; i < LANE_DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
      slot_d[LANE_DEPTH-1] = chart_valid ? chart_notes : '0;
      if (!chart_valid) underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      gameclk_q  <= 1'b0;
      underrun_q <= 1'b0;
      for (int i = 0; i < LANE_DEPTH; i++) slot_q[i] <= '0;
    end else begin
      div_q      <= div_d;
      gameclk_q  <= gameclk_d;
      underrun_q <= underrun_d;
      for (int i = 0; i < LANE_DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    lanes_flat = '0;
    for (int i = 0; i < LANE_DEPTH; i++) lanes_flat[NUM_LANES*i +: NUM_LANES] = slot_q[i];
  end

  assign chart_ready   = tick;
  assign buttons       = db_stable[NUM_LANES-1:0];
  assign strum         = db_stable[NUM_LANES];
  assign gameclk       = gameclk_q;
  assign intersections = slot_q[HIT_POS];
  assign underrun      = underrun_q;
endmodule

// File: tb/tb_guitar_input_frontend.sv
// Directed bench for guitar_input_frontend with a tick-driven scoreboard on {underrun, lanes_flat}.
module tb_guitar_input_frontend;
  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;
  localparam int DEPTH   = 4;
  localparam int HIT     = 1;
  localparam int W       = 4*DEPTH + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0]        btn_raw;
  logic              strum_raw;
  logic              run;
  logic [3:0]        chart_notes;
  logic              chart_valid;
  logic              chart_ready;
  logic [3:0]        buttons;
  logic              strum;
  logic              gameclk;
  logic [3:0]        intersections;
  logic [4*DEPTH-1:0] lanes_flat;
  logic              underrun;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  guitar_input_frontend #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DEB), .LANE_DEPTH(DEPTH), .HIT_POS(HIT)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .strum_raw(strum_raw), .run(run),
    .chart_notes(chart_notes), .chart_valid(chart_valid), .chart_ready(chart_ready),
    .buttons(buttons), .strum(strum), .gameclk(gameclk), .intersections(intersections),
    .lanes_flat(lanes_flat), .underrun(underrun)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " buttons"},       32'(buttons), 32'h0);
    chk({tag, " strum"},         32'(strum), 32'h0);
    chk({tag, " gameclk"},       32'(gameclk), 32'h0);
    chk({tag, " intersections"}, 32'(intersections), 32'h0);
    chk({tag, " lanes_flat"},    32'(lanes_flat), 32'h0);
    chk({tag, " underrun"},      32'(underrun), 32'h0);
    chk({tag, " chart_ready"},   32'(chart_ready), 32'h0);
  endtask

  // Push the pre-shift state expected at the coming tick, present the row, wait for the tick.
  task automatic next_tick(input logic [3:0] row, input logic valid,
                           input logic [15:0] pre_lanes, input logic pre_under);
    bit seen = 0;
    chart_notes = row;
    chart_valid = valid;
    exp_q.push_back({pre_under, pre_lanes});
    for (int i = 0; i < 24 && !seen; i++) begin
      @(negedge clock);
      if (chart_ready) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL tick_timeout: got no chart_ready expected a tick within 24 cycles");
      void'(exp_q.pop_back());
    end
    step(1);
    chk("chart_ready_pulse", 32'(chart_ready), 32'h0);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (reset && chart_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_tick: got chart_ready=1 lanes=%0h expected no tick at %0t",
                 lanes_flat, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({underrun, lanes_flat} !== e) begin
          n_err++;
          $display("FAIL tick_state: got %0h expected %0h at %0t", {underrun, lanes_flat}, e, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; run = 1'b0; btn_raw = '0; strum_raw = 1'b0;
    chart_notes = '0; chart_valid = 1'b0;

    // 1: reset with toggling inputs, then beat timing
    for (int i = 0; i < 6; i++) begin
      btn_raw     = 4'($urandom_range(0, 15));
      strum_raw   = 1'($urandom_range(0, 1));
      run         = 1'($urandom_range(0, 1));
      chart_notes = 4'($urandom_range(0, 15));
      chart_valid = 1'($urandom_range(0, 1));
      step(1);
      chk_all_zero("in_reset");
    end
    btn_raw = '0; strum_raw = 1'b0; run = 1'b1; chart_notes = '0; chart_valid = 1'b1;
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b0, 16'h0000});
    reset = 1'b1;
    step(3);
    chk("gameclk_e3", 32'(gameclk), 32'h0);
    chk("tick_e3", 32'(chart_ready), 32'h1);
    step(1);
    chk("gameclk_e4", 32'(gameclk), 32'h1);
    chk("ready_e4", 32'(chart_ready), 32'h0);
    step(4);
    chk("gameclk_e8", 32'(gameclk), 32'h0);
    step(4);
    chk("gameclk_e12", 32'(gameclk), 32'h1);
    run = 1'b0;

    // 2: debounce latency and glitch rejection (beat frozen)
    btn_raw = 4'b0101;
    step(4);
    chk("buttons_e4", 32'(buttons), 32'h0);
    step(1);
    chk("buttons_e5", 32'(buttons), 32'h5);
    strum_raw = 1'b1;
    step(2);
    strum_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("strum_glitch", 32'(strum), 32'h0);
    end
    chk("frozen_gameclk", 32'(gameclk), 32'h1);

    // 3: chart rows scroll to the hit slot
    run = 1'b1;
    next_tick(4'b1000, 1'b1, 16'h0000, 1'b0);
    chk("lanes_A", 32'(lanes_flat), 32'h8000);
    chk("hit_A", 32'(intersections), 32'h0);
    next_tick(4'b0100, 1'b1, 16'h8000, 1'b0);
    chk("lanes_B", 32'(lanes_flat), 32'h4800);
    next_tick(4'b0000, 1'b1, 16'h4800, 1'b0);
    chk("lanes_C", 32'(lanes_flat), 32'h0480);
    chk("hit_C", 32'(intersections), 32'h8);
    next_tick(4'b0001, 1'b1, 16'h0480, 1'b0);
    chk("lanes_D", 32'(lanes_flat), 32'h1048);
    chk("hit_D", 32'(intersections), 32'h4);
    next_tick(4'b0000, 1'b1, 16'h1048, 1'b0);
    chk("hit_E", 32'(intersections), 32'h0);
    next_tick(4'b0000, 1'b1, 16'h0104, 1'b0);
    chk("hit_F", 32'(intersections), 32'h1);
    chk("lanes_F", 32'(lanes_flat), 32'h0010);

    // 4: underrun inserts an empty row and sticks
    next_tick(4'b1111, 1'b0, 16'h0010, 1'b0);
    chk("lanes_G", 32'(lanes_flat), 32'h0001);
    chk("underrun_G", 32'(underrun), 32'h1);
    next_tick(4'b0110, 1'b1, 16'h0001, 1'b1);
    chk("lanes_H", 32'(lanes_flat), 32'h6000);
    next_tick(4'b1001, 1'b1, 16'h6000, 1'b1);
    chk("lanes_I", 32'(lanes_flat), 32'h9600);
    chk("underrun_I", 32'(underrun), 32'h1);

    // 5: pause mid half-period, debounce keeps running
    step(2);
    run = 1'b0;
    btn_raw = 4'b1010;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      chk("pause_gameclk", 32'(gameclk), 32'h1);
      chk("pause_lanes", 32'(lanes_flat), 32'h9600);
      if (i == 5) chk("pause_buttons", 32'(buttons), 32'ha);
    end
    run = 1'b1;
    step(1);
    chk("resume_e1", 32'(gameclk), 32'h1);
    step(1);
    chk("resume_e2", 32'(gameclk), 32'h0);
    next_tick(4'b0011, 1'b1, 16'h9600, 1'b1);
    chk("lanes_J", 32'(lanes_flat), 32'h3960);

    // 6: asynchronous reset mid-song
    step(1);
    reset = 1'b0;
    #2;
    chk_all_zero("async_reset");
    step(1);
    chart_notes = '0; chart_valid = 1'b1;
    exp_q.push_back({1'b0, 16'h0000});
    reset = 1'b1;
    step(3);
    chk("restart_tick", 32'(chart_ready), 32'h1);
    step(1);
    chk("restart_gameclk", 32'(gameclk), 32'h1);
    run = 1'b0;
    step(5);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missed_ticks: got %0d entries left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
